// File: rtl/pkg_mlpolar.sv
// rtl/pkg_mlpolar.sv - polar core constants and frame sequencer types
//
// Shared by the frame controller and its beat counters.
//   N            : PPM symbols per coded frame
//   K_INFO_DEF   : default info bits per frame
//   INFO_CNT_W   : info counter width for the default frame
//   SYM_CNT_W    : symbol counter width for the default frame
//   DEC_CNT_W    : decoded-bit counter width (saturating)
//   cnt_width()  : bits needed to hold 0..limit inclusive
//   frame_state_t: frame sequencer states
package pkg_mlpolar;

    localparam int N          = 2048;
    localparam int K_INFO_DEF = 1588;
    localparam int DEC_CNT_W  = 12;

    localparam int INFO_CNT_W = $clog2(K_INFO_DEF + 1);
    localparam int SYM_CNT_W  = $clog2(N + 1);

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        XFER,
        DECODE,
        DONE
    } frame_state_t;

endpackage

// File: rtl/hs_counter.sv
// rtl/hs_counter.sv - handshake beat counter with limit compare
//
// Counts accepted beats up to LIMIT and holds there.
//   clk       : clock
//   rst       : synchronous active-high reset
//   clr       : synchronous clear
//   inc       : one accepted beat this cycle
//   at_limit  : count has reached LIMIT
//   last_beat : this cycle's beat brings the count to LIMIT
module hs_counter #(
    parameter int LIMIT = 1,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit,
    output logic last_beat
);

    localparam logic [W-1:0] LIM    = W'(LIMIT);
    localparam logic [W-1:0] LIM_M1 = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit  = (cnt == LIM);
    assign last_beat = inc && (cnt == LIM_M1);

endmodule

// File: rtl/mlpolar_frame_ctrl.sv
// rtl/mlpolar_frame_ctrl.sv - frame sequencer around the polar encoder/decoder core
//
// Gates host info bits into the encoder, meters PPM symbols to the channel
// and observations back to the decoder, closes the frame on decoder block
// completion, and aborts a stalled frame with a no-progress watchdog.
//   clk_12mhz, rst                  : clock, synchronous active-high reset
//   start / busy / done             : frame control and status
//   err_timeout, err_count          : frame status, valid with done
//   frame_cnt                       : completed frames, wraps
//   host_valid/host_ready/host_bit  : host info-bit stream
//   enc_valid/enc_ready/enc_bit     : info bits to the core encoder
//   ppm_valid/ppm_ready_core        : core PPM output handshake
//   ppm_ready_ch                    : channel backpressure
//   obs_valid_ch/obs_ready_ch       : observations from the channel
//   obs_valid_core/obs_ready_core   : observations to the core
//   dec_valid/dec_block_done        : decoder outputs, monitored only
module mlpolar_frame_ctrl
    import pkg_mlpolar::*;
#(
    parameter int K_INFO   = K_INFO_DEF,
    parameter int N_SYM    = N,
    parameter int WDOG_CYC = 65535
) (
    input  logic        clk_12mhz,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_count,
    output logic [15:0] frame_cnt,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_bit,
    output logic        enc_valid,
    input  logic        enc_ready,
    output logic        enc_bit,
    input  logic        ppm_valid,
    output logic        ppm_ready_core,
    input  logic        ppm_ready_ch,
    input  logic        obs_valid_ch,
    output logic        obs_ready_ch,
    output logic        obs_valid_core,
    input  logic        obs_ready_core,
    input  logic        dec_valid,
    input  logic        dec_block_done
);

    localparam int INFO_W = cnt_width(K_INFO);
    localparam int SYM_W  = cnt_width(N_SYM);
    localparam int WDOG_W = cnt_width(WDOG_CYC);

    localparam logic [WDOG_W-1:0]    WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
    localparam logic [DEC_CNT_W-1:0] DEC_MAX   = '1;
    localparam logic [DEC_CNT_W-1:0] DEC_EXP   = DEC_CNT_W'(K_INFO);

    frame_state_t state, state_nxt;

    logic                 info_full, info_last;
    logic                 tx_full, tx_last;
    logic                 rx_full, rx_last;
    logic                 enc_hs, tx_hs, rx_hs;
    logic                 dec_beat, activity, active, gate;
    logic                 wdog_fire, timeout_q;
    logic [WDOG_W-1:0]    wdog_cnt;
    logic [DEC_CNT_W-1:0] dec_cnt;

    // Gated outputs also drop during the reset cycle itself.
    assign gate = !rst;

    assign enc_valid      = gate && (state == LOAD) && host_valid;
    assign host_ready     = gate && (state == LOAD) && enc_ready;
    assign enc_bit        = gate && (state == LOAD) && host_bit;
    assign ppm_ready_core = gate && (state == XFER) && ppm_ready_ch && !tx_full;
    assign obs_valid_core = gate && (state == XFER) && obs_valid_ch && !rx_full;
    assign obs_ready_ch   = gate && (state == XFER) && obs_ready_core && !rx_full;

    assign enc_hs   = enc_valid && enc_ready;
    assign tx_hs    = ppm_valid && ppm_ready_core;
    assign rx_hs    = obs_valid_core && obs_ready_core;
    assign dec_beat = (state == DECODE) && dec_valid;
    assign activity = enc_hs || tx_hs || rx_hs || dec_beat;
    assign active   = (state == LOAD) || (state == XFER) || (state == DECODE);

    hs_counter #(.LIMIT(K_INFO), .W(INFO_W)) u_info_cnt (
        .clk       (clk_12mhz),
        .rst       (rst),
        .clr       (state == IDLE),
        .inc       (enc_hs),
        .at_limit  (info_full),
        .last_beat (info_last)
    );

    hs_counter #(.LIMIT(N_SYM), .W(SYM_W)) u_tx_cnt (
        .clk       (clk_12mhz),
        .rst       (rst),
        .clr       (state == IDLE),
        .inc       (tx_hs),
        .at_limit  (tx_full),
        .last_beat (tx_last)
    );

    hs_counter #(.LIMIT(N_SYM), .W(SYM_W)) u_rx_cnt (
        .clk       (clk_12mhz),
        .rst       (rst),
        .clr       (state == IDLE),
        .inc       (rx_hs),
        .at_limit  (rx_full),
        .last_beat (rx_last)
    );

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wdog_fire = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (info_last) state_nxt = XFER;
            XFER:    if ((tx_full || tx_last) && (rx_full || rx_last)) state_nxt = DECODE;
            DECODE:  if (dec_block_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // The watchdog only fires in a cycle that is itself idle; this is
        // the WDOG_CYC-th idle cycle in a row.
        if (active && (state_nxt == state) && !activity && (wdog_cnt == WDOG_LAST)) begin
            state_nxt = DONE;
            wdog_fire = 1'b1;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst || !active || activity || (state_nxt != state)) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst || (state == IDLE)) begin
            timeout_q <= 1'b0;
        end else if (wdog_fire) begin
            timeout_q <= 1'b1;
        end
    end

    // A bit arriving together with dec_block_done is counted before DONE.
    always_ff @(posedge clk_12mhz) begin
        if (rst || (state == IDLE)) begin
            dec_cnt <= '0;
        end else if (dec_beat && (dec_cnt != DEC_MAX)) begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state == DONE) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign err_timeout = done && timeout_q;
    assign err_count   = done && !timeout_q && (dec_cnt != DEC_EXP);

endmodule
